spi_receiver: RTL and testbench
===============================

# spi_receiver

Serial-to-parallel receive stage sitting directly downstream of the SPI master controller: it consumes that block's `sclk`, `cs_bar` and `mosi` lines and delivers each 8-bit frame as a parallel byte with a valid/ready handshake. `sclk` is treated as a slow data signal: it is oversampled on the system clock and never used as a clock. Frames are LSB-first. A byte is complete after 8 data bits, and error flags report short frames and unconsumed bytes.

## Interface
- DATA_W, 8: bits per frame.
- LEAD_EDGES, 1: falling `sclk` edges after `cs_bar` assertion that are discarded before the first data bit (the master drives bit 0 one `sclk` period after asserting `cs_bar`).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  serial clock from master; asynchronous to `clk`.
- cs_bar  in  1  active-low frame select; asynchronous.
- mosi  in  1  serial data; asynchronous.
- dout  out  DATA_W  received byte, bit 0 = first bit received.
- dout_valid  out  1  `dout` holds an unconsumed byte.
- dout_ready  in  1  downstream accepts `dout` when high together with `dout_valid`.
- overrun  out  1  sticky: a byte completed while `dout_valid` was high.
- frame_err  out  1  one-cycle pulse: frame ended with the wrong bit count.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input conditioning: `sclk`, `cs_bar` and `mosi` each pass through a 2-flop synchronizer, giving `sclk_s`, `cs_s` and `mosi_s`. A history flop `sclk_d` follows `sclk_s`. A falling edge is defined as `fall = sclk_d & ~sclk_s`.
- FSM states:
  - IDLE → LEAD when `cs_s` = 0. Clear `lead_cnt` and `bit_cnt`.
  - LEAD: each `fall` increments `lead_cnt`. When `lead_cnt` reaches LEAD_EDGES → SHIFT. If `cs_s` = 1 → IDLE, with no error.
  - SHIFT: on each `fall`, the shift register updates as `shreg <= {mosi_s, shreg[DATA_W-1:1]}` and `bit_cnt` increments. On the DATA_W-th bit → DONE and the byte is committed (see below). If `cs_s` = 1 with `bit_cnt` in 1..DATA_W-1 → pulse `frame_err`, discard the partial byte, → IDLE. If `cs_s` = 1 with `bit_cnt` = 0 → IDLE, with no error.
  - DONE: if `cs_s` = 1 → IDLE. Any `fall` seen in DONE pulses `frame_err`; the byte already committed is unaffected.
- Commit, when `dout_valid` = 0: `dout` takes the full new byte, i.e. {`mosi_s`, `shreg[DATA_W-1:1]`}, and `dout_valid` is set to 1.
- Commit, when `dout_valid` = 1 and `dout_ready` = 0: the new byte is dropped, `dout` is unchanged, and `overrun` is set to 1.
- Commit in the same cycle as a handshake (`dout_valid` and `dout_ready` both high): the old byte counts as consumed. The new byte loads and `dout_valid` stays 1, with no overrun.
- Handshake with no commit in the same cycle: `dout_valid` and `dout_ready` both high → `dout_valid` clears next cycle. `dout` holds its last value.
- `overrun` is cleared only by reset.
- Reset (`rst` = 0, at any time, including mid-frame):
  - state = IDLE;
  - `dout` = 0, `dout_valid` = 0, `overrun` = 0, `frame_err` = 0, `busy` = 0;
  - shift register, counters and synchronizer flops = 0, except the `cs_bar` synchronizer flops, which reset to 1.
- A frame in progress when reset releases is ignored: after reset the FSM waits in IDLE. If `cs_s` is already 0 it enters LEAD, and a truncated frame produces `frame_err` or is dropped.

## Timing
- Minimum `sclk` high or low time is 3 `clk` cycles. The master's half-period of 51 cycles satisfies this.
- Latency: `dout_valid` rises at the 3rd rising `clk` edge after the raw `sclk` falling edge that carries the last bit.
- `frame_err` rises at the 3rd rising `clk` edge after the raw `cs_bar` rise that ends a short frame, or after the raw `sclk` fall that causes an extra edge in DONE. It stays high for exactly one cycle.
- A `mosi` transition on the same raw edge as `sclk` rises is safe: sampling occurs on falls, mid-bit.
- Back-to-back frames need no gap beyond `cs_bar` being high for at least 3 `clk` cycles, so that IDLE is observed.

## Structure
- Package `spi_pkg` holds:
  - the state enum `rx_state_t` {IDLE, LEAD, SHIFT, DONE};
  - `DATA_W_DEF` = 8 and `LEAD_EDGES_DEF` = 1, both shared with the master;
  - the constant `SYNC_STAGES` = 2.
- Sub-module `spi_sync`: a parameterized N-stage synchronizer with a reset-value parameter, instantiated three times.

## Test plan
- Transmission from the master: master sends 8'hA5, `dout_ready` tied 1 → one `dout_valid` pulse with `dout` = 8'hA5, no `frame_err`, no `overrun`.
- Backpressure: `dout_ready` = 0, master sends 8'h3C then 8'hC3 → `dout` stays 8'h3C with `dout_valid` high, `overrun` = 1. Then raise `dout_ready` → `dout_valid` clears; `overrun` stays 1 until reset.
- Short frame: drive `cs_bar` low, 1 lead-in fall plus 5 data falls, then `cs_bar` high → `frame_err` pulses for 1 cycle, `dout_valid` stays 0, FSM returns to IDLE.
- Commit and handshake in the same cycle: align `dout_ready` high with the commit of the second byte 8'h0F (first byte 8'h11 pending) → `dout` = 8'h0F, `dout_valid` stays 1, `overrun` = 0.
- Reset mid-frame: assert `rst` = 0 after 4 data bits → all outputs 0 next cycle. Release while `cs_bar` is still low → remaining bits produce `frame_err` or nothing, never a `dout_valid`. The next full frame 8'h5A is received correctly.
- Extra edge: add a 9th data `sclk` fall before `cs_bar` rises → the byte is delivered, then `frame_err` pulses once, `dout` is unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: receiver FSM states and frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  // Frame geometry, identical on the master side.
  localparam int DATA_W_DEF     = 8;
  localparam int LEAD_EDGES_DEF = 1;

  // Flops in each input synchronizer chain.
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for one asynchronous input bit.
// Latency: STAGES clk cycles from input change to q.
// Backpressure: none, free-running.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the chain; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_receiver.sv
// Oversampled SPI slave receive path: LSB-first frames to parallel bytes with valid/ready.
// Latency: dout_valid rises on the 3rd clk edge after the raw sclk fall carrying the last bit.
// Backpressure: a byte completing while dout is still pending is dropped and overrun is set.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEAD_EDGES = LEAD_EDGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_bar,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int LW = (LEAD_EDGES < 1) ? 1 : $clog2(LEAD_EDGES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [LW-1:0] LEAD_LIM = LW'(LEAD_EDGES);

  logic sclk_s, cs_s, mosi_s, sclk_d, fall;
  rx_state_t state, state_nxt;
  logic [LW-1:0]     lead_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic cnt_clr, lead_inc, shift_en, commit, ferr_set;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_bar), .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  // sclk history for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) sclk_d <= 1'b0;
    else      sclk_d <= sclk_s;
  end

  assign fall = sclk_d & ~sclk_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: cs deassertion always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!cs_s) state_nxt = LEAD;
      LEAD:  if (cs_s) state_nxt = IDLE;
             else if (lead_cnt == LEAD_LIM) state_nxt = SHIFT;
      SHIFT: if (cs_s) state_nxt = IDLE;
             else if (fall && bit_cnt == LAST_BIT) state_nxt = DONE;
      DONE:  if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: per-state datapath strobes.
  always_comb begin
    cnt_clr  = 1'b0;
    lead_inc = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    ferr_set = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:  cnt_clr = 1'b1;
      LEAD:  lead_inc = !cs_s && fall && (lead_cnt != LEAD_LIM);
      SHIFT: begin
        if (cs_s) begin
          ferr_set = (bit_cnt != '0);
        end else if (fall) begin
          shift_en = 1'b1;
          commit   = (bit_cnt == LAST_BIT);
        end
      end
      DONE:  ferr_set = fall;
      default: cnt_clr = 1'b1;
    endcase
  end

  // Counters, shift register and output byte with valid/ready and overrun tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lead_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (cnt_clr) begin
        lead_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
      end
      if (lead_inc) lead_cnt <= lead_cnt + LW'(1);
      if (shift_en) begin
        shreg   <= {mosi_s, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (commit) begin
        // A handshake in the same cycle frees the slot for the new byte.
        if (!dout_valid || dout_ready) begin
          dout       <= {mosi_s, shreg[DATA_W-1:1]};
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: directed table, hand sequences, random frames.
// Latency: n/a.
// Backpressure: dout_ready driven by table, sequences or randomly.
module tb_spi_receiver;

  localparam int H = 6;  // sclk half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_bar = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int vrise = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic [7:0] got[$];
  bit rnd_ready = 1'b0;

  spi_receiver dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_bar(cs_bar), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor away from the active edge: consumed bytes, valid rises, error pulses.
  always @(negedge clk) begin
    if (dout_valid && dout_ready) got.push_back(dout);
    if (dout_valid && !prev_v) vrise++;
    if (frame_err) begin
      ferr_cnt++;
      chk("frame_err_width", {31'd0, prev_f}, 32'd0);
    end
    prev_v = dout_valid;
    prev_f = frame_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sedge(input logic b);
    sclk = 1'b1;
    mosi = b;
    repeat (H) tick();
    sclk = 1'b0;
    repeat (H) tick();
  endtask

  // Last data edge with dout_ready pulsed exactly on the commit edge.
  task automatic sedge_hs(input logic b);
    sclk = 1'b1;
    mosi = b;
    repeat (H) tick();
    sclk = 1'b0;
    tick();
    tick();
    chk("hs_pre_commit_dout", {24'd0, dout}, 32'h11);
    chk("hs_pre_commit_valid", {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("hs_dout", {24'd0, dout}, 32'h0F);
    chk("hs_valid", {31'd0, dout_valid}, 32'd1);
    chk("hs_overrun", {31'd0, overrun}, 32'd0);
    repeat (H - 3) tick();
  endtask

  task automatic lead_in();
    cs_bar = 1'b0;
    repeat (H) tick();
    sedge(1'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit hs);
    logic [7:0] v;
    v = d;
    lead_in();
    for (int i = 0; i < nbits; i++) begin
      if (hs && i == 7) sedge_hs(v[i % 8]);
      else              sedge(v[i % 8]);
    end
    cs_bar = 1'b1;
    repeat (H + 4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       rdy;
    logic [7:0] e_dout;
    logic       e_valid;
    logic       e_ovr;
    int         e_ferr;
    int         e_rise;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int f0, r0, g0, n_exp_ferr;
    logic [7:0] exp_q[$];

    tbl[0] = '{8'hA5, 8, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 1};  // full frame, ready high
    tbl[1] = '{8'hFF, 5, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 0};  // short frame
    tbl[2] = '{8'h3C, 8, 1'b0, 8'h3C, 1'b1, 1'b0, 0, 1};  // held under backpressure
    tbl[3] = '{8'hC3, 8, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 0};  // dropped, overrun
    tbl[4] = '{8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 0};  // lead-in only, no error

    // Reset state
    repeat (3) tick();
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // Directed table
    for (int k = 0; k < 5; k++) begin
      f0 = ferr_cnt;
      r0 = vrise;
      dout_ready = tbl[k].rdy;
      send_frame(tbl[k].data, tbl[k].nbits, 1'b0);
      chk($sformatf("tbl%0d_dout", k), {24'd0, dout}, {24'd0, tbl[k].e_dout});
      chk($sformatf("tbl%0d_valid", k), {31'd0, dout_valid}, {31'd0, tbl[k].e_valid});
      chk($sformatf("tbl%0d_overrun", k), {31'd0, overrun}, {31'd0, tbl[k].e_ovr});
      chk($sformatf("tbl%0d_ferr", k), 32'(ferr_cnt - f0), 32'(tbl[k].e_ferr));
      chk($sformatf("tbl%0d_vrise", k), 32'(vrise - r0), 32'(tbl[k].e_rise));
      chk($sformatf("tbl%0d_busy", k), {31'd0, busy}, 32'd0);
    end

    // Release backpressure: pending byte drains, overrun is sticky
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("drain_valid", {31'd0, dout_valid}, 32'd0);
    chk("drain_dout", {24'd0, dout}, 32'h3C);
    repeat (5) tick();
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Extra sclk edge after a full byte
    do_reset();
    chk("reset_clears_overrun", {31'd0, overrun}, 32'd0);
    f0 = ferr_cnt;
    r0 = vrise;
    send_frame(8'h96, 9, 1'b0);
    chk("extra_dout", {24'd0, dout}, 32'h96);
    chk("extra_valid", {31'd0, dout_valid}, 32'd1);
    chk("extra_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("extra_vrise", 32'(vrise - r0), 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Commit coinciding with a handshake
    send_frame(8'h11, 8, 1'b0);
    chk("first_pending", {31'd0, dout_valid}, 32'd1);
    send_frame(8'h0F, 8, 1'b1);
    chk("after_hs_overrun", {31'd0, overrun}, 32'd0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Reset in the middle of a frame, released with cs_bar still low
    r0 = vrise;
    lead_in();
    for (int i = 0; i < 4; i++) sedge(1'b1);
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) sedge(1'b0);
    cs_bar = 1'b1;
    repeat (H + 4) tick();
    chk("midrst_no_valid", 32'(vrise - r0), 32'd0);
    send_frame(8'h5A, 8, 1'b0);
    chk("post_rst_dout", {24'd0, dout}, 32'h5A);
    chk("post_rst_valid", {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Random frames against a frame-level model
    do_reset();
    f0 = ferr_cnt;
    g0 = got.size();
    n_exp_ferr = 0;
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      int r, nb;
      d = 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 6)       nb = 8;
      else if (r == 6) nb = int'($urandom_range(0, 7));
      else             nb = int'($urandom_range(9, 10));
      if (nb >= 8) exp_q.push_back(d);
      if (nb >= 1 && nb <= 7) n_exp_ferr += 1;
      if (nb > 8) n_exp_ferr += nb - 8;
      send_frame(d, nb, 1'b0);
    end
    repeat (20) tick();
    rnd_ready = 1'b0;
    dout_ready = 1'b0;
    chk("rnd_count", 32'(got.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (g0 + i) < got.size(); i++)
      chk($sformatf("rnd_byte%0d", i), {24'd0, got[g0 + i]}, {24'd0, exp_q[i]});
    chk("rnd_ferr", 32'(ferr_cnt - f0), 32'(n_exp_ferr));
    chk("rnd_overrun", {31'd0, overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
